// File: rtl/sc_spil_arb.sv
// sc_spil_arb: round-robin arbiter sharing one SPI Lite engine between
// NUM_OF_REQ requesters. Sequences start / wait / respond per word and keeps
// the grant plus chip select for multi-word bursts until the LAST word.
module sc_spil_arb #(
  parameter int NUM_OF_REQ = 4,
  parameter int TIMEOUT    = 4096
) (
  input  logic                     SYSCLK,
  input  logic                     SYSRSTB,
  input  logic [NUM_OF_REQ-1:0]    REQ_VALID,
  output logic [NUM_OF_REQ-1:0]    REQ_READY,
  input  logic [NUM_OF_REQ*5-1:0]  REQ_CSSEL,
  input  logic [NUM_OF_REQ*9-1:0]  REQ_DWIDTH,
  input  logic [NUM_OF_REQ*32-1:0] REQ_TXDATA,
  input  logic [NUM_OF_REQ-1:0]    REQ_LAST,
  output logic [NUM_OF_REQ-1:0]    RSP_VALID,
  output logic [31:0]              RSP_RXDATA,
  output logic                     RSP_ERR,
  output logic [NUM_OF_REQ-1:0]    GRANT,
  output logic [4:0]               CSSEL,
  output logic [8:0]               DWIDTH,
  output logic [31:0]              TXDATA,
  output logic                     CSEXTEND,
  output logic                     TXSTART,
  input  logic                     SPIBUSY,
  input  logic                     SPICOMPLETE,
  input  logic [31:0]              RXDATA
);
  localparam int PW = (NUM_OF_REQ > 1) ? $clog2(NUM_OF_REQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_RESP, S_LOCK} state_t;

  typedef struct packed {
    logic [4:0]  cssel;
    logic [8:0]  dwidth;
    logic [31:0] txdata;
    logic        last;
  } req_t;

  state_t                        r_state;
  logic [PW-1:0]                 r_ptr;
  logic [PW-1:0]                 r_own;
  logic [CW-1:0]                 r_cnt;
  logic [NUM_OF_REQ-1:0]         r_grant;
  logic [NUM_OF_REQ-1:0]         r_ready;
  logic [NUM_OF_REQ-1:0]         r_rsp_vld;
  logic                          r_rsp_err;
  logic [31:0]                   r_rsp_rx;
  logic [4:0]                    r_cssel;
  logic [8:0]                    r_dwidth;
  logic [31:0]                   r_txdata;
  logic                          r_last;
  logic                          r_csext;
  logic                          r_txstart;

  req_t [NUM_OF_REQ-1:0]         w_req;
  logic [NUM_OF_REQ-1:0]         w_ge_ptr;
  logic [PW-1:0][NUM_OF_REQ-1:0] w_enc;
  logic [NUM_OF_REQ-1:0]         w_hi;
  logic [NUM_OF_REQ-1:0]         w_pick;
  logic [NUM_OF_REQ-1:0]         w_oh;
  logic [PW-1:0]                 w_win;
  req_t                          w_win_req;
  req_t                          w_own_req;
  logic                          w_own_vld;
  logic [PW-1:0]                 w_ptr_nxt;

  // Per-requester field unpacking, pointer mask and one-hot->index encode table.
  for (genvar g = 0; g < NUM_OF_REQ; g++) begin : g_req
    assign w_req[g]    = {REQ_CSSEL[g*5 +: 5], REQ_DWIDTH[g*9 +: 9],
                          REQ_TXDATA[g*32 +: 32], REQ_LAST[g]};
    assign w_ge_ptr[g] = (PW'(g) >= r_ptr);
    for (genvar b = 0; b < PW; b++) begin : g_bit
      assign w_enc[b][g] = 1'(((g >> b) & 1));
    end
  end

  // Round robin: lowest valid at/after PTR, else wrap to lowest valid overall.
  assign w_hi   = REQ_VALID & w_ge_ptr;
  assign w_pick = (|w_hi) ? w_hi : REQ_VALID;
  assign w_oh   = w_pick & (~w_pick + NUM_OF_REQ'(1));
  for (genvar b = 0; b < PW; b++) begin : g_win
    assign w_win[b] = |(w_oh & w_enc[b]);
  end

  assign w_win_req = w_req[w_win];
  assign w_own_req = w_req[r_own];
  assign w_own_vld = |(REQ_VALID & r_grant);
  assign w_ptr_nxt = (r_own == PW'(NUM_OF_REQ - 1)) ? '0 : r_own + PW'(1);

  // Main sequencer: arbitration, engine start, completion/timeout, response, burst lock.
  always_ff @(posedge SYSCLK) begin
    if (!SYSRSTB) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_own     <= '0;
      r_cnt     <= '0;
      r_grant   <= '0;
      r_ready   <= '0;
      r_rsp_vld <= '0;
      r_rsp_err <= 1'b0;
      r_rsp_rx  <= '0;
      r_cssel   <= '0;
      r_dwidth  <= '0;
      r_txdata  <= '0;
      r_last    <= 1'b0;
      r_csext   <= 1'b0;
      r_txstart <= 1'b0;
    end else begin
      r_ready   <= '0;
      r_rsp_vld <= '0;
      r_txstart <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (|REQ_VALID) begin
            r_own    <= w_win;
            r_grant  <= w_oh;
            r_ready  <= w_oh;
            r_cssel  <= w_win_req.cssel;
            r_dwidth <= w_win_req.dwidth;
            r_txdata <= w_win_req.txdata;
            r_last   <= w_win_req.last;
            r_csext  <= ~w_win_req.last;
            r_state  <= S_START;
          end
        end
        S_START: begin
          if (!SPIBUSY) begin
            r_txstart <= 1'b1;
            r_cnt     <= '0;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (SPICOMPLETE) begin
            r_rsp_rx  <= RXDATA;
            r_rsp_err <= 1'b0;
            r_rsp_vld <= r_grant;
            r_state   <= S_RESP;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            // Abort: drop CS and end the burst so the grant is released.
            r_rsp_rx  <= '0;
            r_rsp_err <= 1'b1;
            r_csext   <= 1'b0;
            r_last    <= 1'b1;
            r_rsp_vld <= r_grant;
            r_state   <= S_RESP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_RESP, S_LOCK: begin
          if (r_state == S_RESP && r_last) begin
            r_grant <= '0;
            r_csext <= 1'b0;
            r_ptr   <= w_ptr_nxt;
            r_state <= S_IDLE;
          end else if (w_own_vld) begin
            // Next burst word; CSSEL stays at the burst's original target.
            r_ready  <= r_grant;
            r_dwidth <= w_own_req.dwidth;
            r_txdata <= w_own_req.txdata;
            r_last   <= w_own_req.last;
            r_csext  <= ~w_own_req.last;
            r_state  <= S_START;
          end else begin
            r_state <= S_LOCK;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign REQ_READY  = r_ready;
  assign RSP_VALID  = r_rsp_vld;
  assign RSP_RXDATA = r_rsp_rx;
  assign RSP_ERR    = r_rsp_err;
  assign GRANT      = r_grant;
  assign CSSEL      = r_cssel;
  assign DWIDTH     = r_dwidth;
  assign TXDATA     = r_txdata;
  assign CSEXTEND   = r_csext;
  assign TXSTART    = r_txstart;

endmodule
